gshare_predictor: RTL
=====================

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter CTR_WIDTH, default 2, meaning saturating counter width in bits (legal range 2..4).
REQ-002 SHALL have parameter IDX_WIDTH, default 6, meaning table index width; table depth = 2**IDX_WIDTH entries.
REQ-003 SHALL have parameter GHR_WIDTH, default 6, meaning global history register width (legal range 1..IDX_WIDTH).
REQ-004 SHALL have parameter USE_GHR, default 1, meaning 1 = gshare indexing, 0 = bimodal indexing (PC only).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-007 SHALL have port pred_pc, input, 32, meaning fetch PC to predict.
REQ-008 SHALL have port pred_taken, output, 1, meaning prediction for pred_pc (combinational).
REQ-009 SHALL have port pred_ghr, output, GHR_WIDTH, meaning GHR snapshot used for this prediction, carried down the pipe.
REQ-010 SHALL have port upd_valid, input, 1, meaning a resolved branch is presented this cycle.
REQ-011 SHALL have port upd_pc, input, 32, meaning PC of the resolved branch.
REQ-012 SHALL have port upd_ghr, input, GHR_WIDTH, meaning pred_ghr snapshot that travelled with that branch.
REQ-013 SHALL have port upd_taken, input, 1, meaning actual branch outcome.
REQ-014 SHALL have port upd_mispredict, input, 1, meaning the branch was mispredicted; qualified by upd_valid.
REQ-015 SHALL have port mispredict_count, output, 32, meaning count of mispredicted updates.
REQ-016 SHALL have port branch_count, output, 32, meaning count of all valid updates.

Function
REQ-017 SHALL hold 2**IDX_WIDTH counters of CTR_WIDTH bits and one GHR of GHR_WIDTH bits.
REQ-018 SHALL form lookup index = pred_pc[IDX_WIDTH+1:2] XOR zero-extended GHR when USE_GHR=1, else pred_pc[IDX_WIDTH+1:2].
REQ-019 SHALL form update index identically from upd_pc and upd_ghr (not the live GHR).
REQ-020 SHALL drive pred_taken = MSB of the indexed counter, combinationally, zero-cycle latency.
REQ-021 SHALL drive pred_ghr = current GHR when USE_GHR=1, else all zeros.
REQ-022 SHALL, on upd_valid, increment the indexed counter if upd_taken, else decrement, saturating at 2**CTR_WIDTH-1 and 0 (no wrap).
REQ-023 SHALL, on upd_valid with USE_GHR=1, shift GHR left by one with upd_taken entering the LSB; the oldest bit is discarded.
REQ-024 SHALL leave all counters and GHR unchanged when upd_valid=0.
REQ-025 SHALL, when lookup and update hit the same index in one cycle, return the pre-update counter value; the new value is visible the next cycle.
REQ-026 SHALL ignore pred_pc[1:0], upd_pc[1:0] and PC bits above IDX_WIDTH+1 (aliasing permitted).
REQ-027 SHALL increment branch_count on every upd_valid, and mispredict_count on upd_valid and upd_mispredict; both saturate at 32'hFFFFFFFF.
REQ-028 SHALL ignore upd_mispredict when upd_valid=0.

Reset
REQ-029 SHALL, on rst high at a clock edge, set every counter to 2**(CTR_WIDTH-1)-1 (weakly not taken; 2'b01 for CTR_WIDTH=2), GHR to 0, and both count outputs to 0.
REQ-030 SHALL give rst priority over a simultaneous upd_valid; that update is dropped.
REQ-031 SHALL drive pred_taken=0 and pred_ghr=0 for any pred_pc in the cycle after reset.

Verification
REQ-032 Post-reset lookup: rst 1 cycle, pred_pc=0x00000040 -> pred_taken=0, pred_ghr=0, both counts 0.
REQ-033 Saturation (USE_GHR=0, CTR_WIDTH=2): 4 updates upd_pc=0x100 taken -> counter 01->10->11->11, pred_taken=1 after the first; then 3 not-taken -> 10,01,00, pred_taken=0 after the second.
REQ-034 Gshare history (defaults): updates taken,taken,not-taken from GHR=0 -> GHR=6'b000110; pred_pc=0x0 then indexes entry 6.
REQ-035 Same-cycle bypass: upd_valid to index 5 (counter 01, taken) while pred_pc indexes 5 -> pred_taken=0 that cycle, 1 next cycle.
REQ-036 Counters: 10 updates with 3 flagged upd_mispredict, plus 2 cycles upd_valid=0, upd_mispredict=1 -> branch_count=10, mispredict_count=3.
REQ-037 Reset mid-run: rst asserted with upd_valid=1 taken -> all counters 01, GHR 0, counts 0; dropped update has no effect.

Source files
------------

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor.
// A table of saturating counters indexed by PC word bits, optionally XORed with
// a global history register. Lookup is combinational. Updates arrive later,
// carrying the history snapshot that was used at prediction time. Running
// branch and mispredict counts are kept for performance monitoring.
module gshare_predictor #(
   parameter int CTR_WIDTH = 2,
   parameter int IDX_WIDTH = 6,
   parameter int GHR_WIDTH = 6,
   parameter int USE_GHR   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          pred_pc,
   output logic                 pred_taken,
   output logic [GHR_WIDTH-1:0] pred_ghr,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic [GHR_WIDTH-1:0] upd_ghr,
   input  logic                 upd_taken,
   input  logic                 upd_mispredict,
   output logic [31:0]          mispredict_count,
   output logic [31:0]          branch_count
);

   localparam int DEPTH = 1 << IDX_WIDTH;

   // Weakly not-taken: MSB clear, all lower bits set.
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = {1'b0, {(CTR_WIDTH-1){1'b1}}};
   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
   localparam logic [CTR_WIDTH-1:0] CTR_MIN  = '0;

   logic [CTR_WIDTH-1:0] ctr_table [DEPTH];
   logic [GHR_WIDTH-1:0] ghr;

   logic [IDX_WIDTH-1:0] pred_pc_idx;
   logic [IDX_WIDTH-1:0] upd_pc_idx;
   logic [IDX_WIDTH-1:0] ghr_ext;
   logic [IDX_WIDTH-1:0] upd_ghr_ext;
   logic [IDX_WIDTH-1:0] pred_idx;
   logic [IDX_WIDTH-1:0] upd_idx;
   logic [CTR_WIDTH-1:0] upd_ctr_cur;
   logic [CTR_WIDTH-1:0] upd_ctr_next;
   logic [GHR_WIDTH-1:0] ghr_next;

   // Bits outside the index field are deliberately ignored; aliasing between
   // PCs that share index bits is accepted.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[31:IDX_WIDTH+2], pred_pc[1:0],
                             upd_pc[31:IDX_WIDTH+2], upd_pc[1:0]};

   assign pred_pc_idx = pred_pc[IDX_WIDTH+1:2];
   assign upd_pc_idx  = upd_pc[IDX_WIDTH+1:2];
   assign ghr_ext     = IDX_WIDTH'(ghr);
   assign upd_ghr_ext = IDX_WIDTH'(upd_ghr);

   // Update indexes with the snapshot that travelled with the branch, not the
   // live history, so the same counter that produced the prediction is trained.
   assign pred_idx = (USE_GHR != 0) ? (pred_pc_idx ^ ghr_ext)    : pred_pc_idx;
   assign upd_idx  = (USE_GHR != 0) ? (upd_pc_idx ^ upd_ghr_ext) : upd_pc_idx;

   // Read-before-write: a same-cycle update to the looked-up entry is only
   // visible from the following cycle.
   assign pred_taken = ctr_table[pred_idx][CTR_WIDTH-1];
   assign pred_ghr   = (USE_GHR != 0) ? ghr : '0;

   // Saturating step of the counter addressed by the update.
   always_comb begin
      upd_ctr_cur  = ctr_table[upd_idx];
      upd_ctr_next = upd_ctr_cur;
      if (upd_taken) begin
         if (upd_ctr_cur != CTR_MAX) upd_ctr_next = upd_ctr_cur + 1'b1;
      end else begin
         if (upd_ctr_cur != CTR_MIN) upd_ctr_next = upd_ctr_cur - 1'b1;
      end
   end

   // Shift the outcome into the history; the cast drops the oldest bit and
   // also covers a one-bit history.
   assign ghr_next = GHR_WIDTH'({ghr, upd_taken});

   // Counter table: reset to weakly not-taken, train on valid updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctr_table[i] <= CTR_INIT;
         end
      end else if (upd_valid) begin
         ctr_table[upd_idx] <= upd_ctr_next;
      end
   end

   // Global history register; held at zero in bimodal mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr <= '0;
      end else if (upd_valid && (USE_GHR != 0)) begin
         ghr <= ghr_next;
      end
   end

   // Saturating branch and mispredict counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (upd_valid) begin
         if (branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
         if (upd_mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
            mispredict_count <= mispredict_count + 32'd1;
         end
      end
   end

endmodule
